life_gen_ctrl: RTL and testbench
================================

Name: life_gen_ctrl

Overview:
- Generation controller for the Game of Life engine. It sits directly downstream of the 1 s divider and consumes that divider's slow toggle output, clk_1s.
- It turns clk_1s into single generation-step requests to the cell-update engine, using a req/done handshake.
- It applies run/pause, single-step and clear controls from debounced push buttons.
- It keeps a generation counter for the display and a sticky overrun flag.

Parameters:
- GEN_W, 16, width of the generation counter.
- DEB_MAX, 20'd1000000, number of clk cycles a raw button level must stay stable before it is accepted. The debounce counter is 20 bits.

Ports:
- clk  in  1  system clock; same clock as the divider.
- rst  in  1  synchronous, active-high reset.
- clk_1s  in  1  toggle from the divider. One generation tick is taken per rising edge.
- btn_run  in  1  raw button; each accepted press toggles run/pause.
- btn_step  in  1  raw button; each accepted press triggers a single step, only while paused.
- btn_clear  in  1  raw button; each accepted press requests a board clear.
- step_req  out  1  level request to the engine to compute one generation.
- clear_req  out  1  level request to the engine to clear the board.
- eng_done  in  1  one-cycle pulse from the engine; acknowledges whichever request is active.
- running  out  1  1 = auto-run mode.
- gen_count  out  GEN_W  number of completed generations.
- overrun  out  1  sticky; a tick arrived while a step was still busy.

Behaviour:
- Reset, applied at any time including mid-handshake. On the next clk edge:
  - step_req=0, clear_req=0, running=0, gen_count=0, overrun=0.
  - FSM goes to PAUSE.
  - Debouncer counters=0 and stable levels=0.
  - clk_1s_d=1, so no spurious tick on the first cycle after reset.
- Tick:
  - tick = clk_1s & ~clk_1s_d, with clk_1s_d registered every cycle.
  - With divider setting f, one tick occurs every 2*(f+1) cycles.
- Debounce, per button:
  - While raw != stable, the counter increments; otherwise it clears.
  - When the counter reaches DEB_MAX-1, stable <= raw and the counter clears.
  - A press is a one-cycle pulse on a 0->1 change of stable.
  - A raw glitch shorter than DEB_MAX cycles produces no press.
- FSM states: PAUSE, RUN, STEP_BUSY, CLEAR_BUSY.
  - PAUSE:
    - clear press -> CLEAR_BUSY.
    - else step press -> STEP_BUSY.
    - else run press -> RUN, running=1.
    - Ticks are ignored.
  - RUN:
    - clear press -> CLEAR_BUSY.
    - else run press -> PAUSE, running=0.
    - else tick -> STEP_BUSY.
    - Step presses are ignored.
  - STEP_BUSY:
    - step_req=1 from the cycle after entry until eng_done is sampled 1.
    - On eng_done: gen_count <= gen_count+1. It wraps from 2^GEN_W-1 to 0 with no flag.
    - Next state is CLEAR_BUSY if a clear is pending, else RUN if running=1, else PAUSE.
    - A run press while busy toggles running immediately; the new value takes effect at exit.
    - A clear press while busy sets clear_pending.
    - A tick while busy sets overrun=1 and is dropped, never queued.
    - A step press while busy is dropped.
  - CLEAR_BUSY:
    - clear_req=1 until eng_done.
    - On eng_done: gen_count=0, overrun=0, running=0, clear_pending=0; then -> PAUSE.
    - All presses and ticks are ignored.
- Priority within one cycle: clear > step > run > tick.
- Latency:
  - Tick or press at cycle n -> state change at edge n+1 -> step_req/clear_req high from cycle n+1.
  - eng_done at cycle m -> req low and gen_count updated in cycle m+1.
- Outputs:
  - step_req and clear_req are registered and never high together.
  - An eng_done received in PAUSE or RUN is ignored.
- Implementation size: about 150-250 lines RTL.

Test Plan (DEB_MAX=4, divider f=9 so one tick every 20 cycles, engine model returns eng_done 3 cycles after req rises):
1. Reset, then 100 idle cycles with clk_1s toggling -> step_req stays 0, running=0, gen_count=0.
2. btn_run held high for 6 cycles -> running=1. Each following clk_1s rise -> step_req high the next cycle for exactly 3 cycles. After 5 ticks gen_count=5 and overrun=0.
3. Engine delay raised to 25 cycles while in RUN -> overrun=1 after the second tick. Dropped ticks do not queue: gen_count advances once per completed handshake.
4. In PAUSE, a 2-cycle glitch on btn_step -> no request. A 6-cycle press -> exactly one step_req and gen_count +1. btn_step pressed in RUN -> no effect.
5. btn_clear pressed during STEP_BUSY -> the step completes (gen_count +1), then clear_req asserts. After eng_done: gen_count=0, overrun=0, running=0, state PAUSE.
6. rst asserted while step_req=1 -> step_req=0 on the next edge. gen_count preset near wrap (GEN_W=4, 15 steps, then one more) -> gen_count wraps to 0. clk_1s held high across reset release -> no tick.

Source files
------------

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: generation controller for the Game of Life engine.
// Turns the divider's slow clk_1s toggle into single-step requests to the
// cell-update engine (req/done handshake), applies debounced run/step/clear
// buttons, and keeps a generation counter plus a sticky overrun flag.
module life_gen_ctrl #(
  parameter int          GEN_W   = 16,
  parameter logic [19:0] DEB_MAX = 20'd1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_1s,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_clear,
  output logic             step_req,
  output logic             clear_req,
  input  logic             eng_done,
  output logic             running,
  output logic [GEN_W-1:0] gen_count,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_PAUSE      = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP_BUSY  = 2'd2,
    ST_CLEAR_BUSY = 2'd3
  } state_t;

  // Button index map: 0 = run, 1 = step, 2 = clear.
  logic [2:0] btn_raw;
  logic [2:0] btn_press;
  assign btn_raw = {btn_clear, btn_step, btn_run};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic [19:0] cnt_q, cnt_d;
      logic        stable_q, stable_d;
      logic        press_q, press_d;

      // Count cycles the raw level disagrees with the accepted level; accept it after DEB_MAX
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (btn_raw[gi] != stable_q) begin
          if (cnt_q == DEB_MAX - 20'd1) begin
            stable_d = btn_raw[gi];
            press_d  = btn_raw[gi];
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end

      // Debouncer state; press_q is a one-cycle pulse on an accepted 0->1 change
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
          press_q  <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
          press_q  <= press_d;
        end
      end

      assign btn_press[gi] = press_q;
    end
  endgenerate

  logic press_run, press_step, press_clr;
  assign press_run  = btn_press[0];
  assign press_step = btn_press[1];
  assign press_clr  = btn_press[2];

  // Delayed copy of clk_1s; preset to 1 so a high input at reset release is not a tick
  logic clk_1s_q;
  always_ff @(posedge clk) begin
    if (rst) clk_1s_q <= 1'b1;
    else     clk_1s_q <= clk_1s;
  end

  logic tick;
  assign tick = clk_1s & ~clk_1s_q;

  state_t           state_q, state_d;
  logic             step_req_q, step_req_d;
  logic             clear_req_q, clear_req_d;
  logic             running_q, running_d;
  logic             clear_pend_q, clear_pend_d;
  logic             overrun_q, overrun_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_PAUSE;
    else     state_q <= state_d;
  end

  // Next-state logic; priority clear > step > run > tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: begin
        if (press_clr)       state_d = ST_CLEAR_BUSY;
        else if (press_step) state_d = ST_STEP_BUSY;
        else if (press_run)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_clr)      state_d = ST_CLEAR_BUSY;
        else if (press_run) state_d = ST_PAUSE;
        else if (tick)      state_d = ST_STEP_BUSY;
      end
      ST_STEP_BUSY: begin
        // A run press in the same cycle as eng_done already counts for the exit
        if (eng_done) begin
          if (clear_pend_q | press_clr)   state_d = ST_CLEAR_BUSY;
          else if (running_q ^ press_run) state_d = ST_RUN;
          else                            state_d = ST_PAUSE;
        end
      end
      ST_CLEAR_BUSY: begin
        if (eng_done) state_d = ST_PAUSE;
      end
      default: state_d = ST_PAUSE;
    endcase
  end

  // Output/datapath next values; requests follow the next state so they rise with entry
  always_comb begin
    step_req_d   = (state_d == ST_STEP_BUSY);
    clear_req_d  = (state_d == ST_CLEAR_BUSY);
    running_d    = running_q;
    clear_pend_d = clear_pend_q;
    overrun_d    = overrun_q;
    gen_d        = gen_q;
    case (state_q)
      ST_PAUSE: begin
        if (!press_clr && !press_step && press_run) running_d = 1'b1;
      end
      ST_RUN: begin
        if (!press_clr && press_run) running_d = 1'b0;
      end
      ST_STEP_BUSY: begin
        if (press_run) running_d    = ~running_q;
        if (press_clr) clear_pend_d = 1'b1;
        if (tick)      overrun_d    = 1'b1;
        if (eng_done)  gen_d        = gen_q + {{(GEN_W-1){1'b0}}, 1'b1};
      end
      ST_CLEAR_BUSY: begin
        if (eng_done) begin
          gen_d        = '0;
          overrun_d    = 1'b0;
          running_d    = 1'b0;
          clear_pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      step_req_q   <= 1'b0;
      clear_req_q  <= 1'b0;
      running_q    <= 1'b0;
      clear_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      gen_q        <= '0;
    end else begin
      step_req_q   <= step_req_d;
      clear_req_q  <= clear_req_d;
      running_q    <= running_d;
      clear_pend_q <= clear_pend_d;
      overrun_q    <= overrun_d;
      gen_q        <= gen_d;
    end
  end

  assign step_req  = step_req_q;
  assign clear_req = clear_req_q;
  assign running   = running_q;
  assign gen_count = gen_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Testbench for life_gen_ctrl: directed button/tick/engine stimulus, a
// behavioural reference model compared every cycle, plus literal checkpoints.
module tb_life_gen_ctrl;

  localparam int GEN_W = 4;
  localparam int DEB   = 4;
  localparam int HALF  = 10;   // divider setting f=9: toggle every 10 cycles

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_1s = 1'b0;
  logic             btn_run = 1'b0;
  logic             btn_step = 1'b0;
  logic             btn_clear = 1'b0;
  logic             eng_done = 1'b0;
  logic             step_req;
  logic             clear_req;
  logic             running;
  logic [GEN_W-1:0] gen_count;
  logic             overrun;

  life_gen_ctrl #(.GEN_W(GEN_W), .DEB_MAX(20'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_1s    (clk_1s),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_clear (btn_clear),
    .step_req  (step_req),
    .clear_req (clear_req),
    .eng_done  (eng_done),
    .running   (running),
    .gen_count (gen_count),
    .overrun   (overrun)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- divider stand-in ----------------
  bit div_en   = 1'b1;
  int div_cnt  = 0;
  int tick_cnt = 0;
  initial forever begin
    @(posedge clk); #2;
    if (div_en) begin
      div_cnt++;
      if (div_cnt == HALF) begin
        div_cnt = 0;
        clk_1s  = ~clk_1s;
        if (clk_1s) tick_cnt++;
      end
    end
  end

  // ---------------- engine stand-in ----------------
  int eng_delay = 3;
  int eng_cnt   = 0;
  initial forever begin
    @(posedge clk); #2;
    if (rst) begin
      eng_cnt = 0; eng_done = 1'b0;
    end else if (eng_done) begin
      eng_done = 1'b0; eng_cnt = 0;
    end else if (step_req || clear_req) begin
      eng_cnt++;
      if (eng_cnt >= eng_delay) eng_done = 1'b1;
    end else begin
      eng_cnt = 0;
    end
  end

  // ---------------- behavioural model ----------------
  // Controller seen as flags: idle (paused or running), stepping, clearing.
  // A button is accepted once its last DEB raw samples all differ from the
  // accepted level; the press is acted on one cycle later.
  bit           m_run, m_step, m_clr, m_pend, m_over, m_prev1s;
  int           m_gen;
  bit [DEB-1:0] m_hist [3];
  bit           m_acc  [3];
  bit           m_press[3];

  task automatic model_step();
    bit raw[3];
    bit tk, p_run, p_step, p_clr;
    raw[0] = btn_run; raw[1] = btn_step; raw[2] = btn_clear;
    if (rst) begin
      m_run = 0; m_step = 0; m_clr = 0; m_pend = 0; m_over = 0; m_gen = 0; m_prev1s = 1;
      for (int b = 0; b < 3; b++) begin m_hist[b] = '0; m_acc[b] = 0; m_press[b] = 0; end
      return;
    end
    tk = clk_1s && !m_prev1s;
    m_prev1s = clk_1s;
    p_run = m_press[0]; p_step = m_press[1]; p_clr = m_press[2];
    if (m_clr) begin
      if (eng_done) begin
        m_clr = 0; m_gen = 0; m_over = 0; m_run = 0; m_pend = 0;
      end
    end else if (m_step) begin
      if (p_run) m_run  = !m_run;
      if (p_clr) m_pend = 1;
      if (tk)    m_over = 1;
      if (eng_done) begin
        m_gen  = (m_gen + 1) % (1 << GEN_W);
        m_step = 0;
        if (m_pend) m_clr = 1;
      end
    end else begin
      if (p_clr)                m_clr  = 1;
      else if (!m_run && p_step) m_step = 1;
      else if (p_run)           m_run  = !m_run;
      else if (m_run && tk)     m_step = 1;
    end
    for (int b = 0; b < 3; b++) begin
      m_hist[b]  = {m_hist[b][DEB-2:0], raw[b]};
      m_press[b] = 0;
      if (m_hist[b] == {DEB{~m_acc[b]}}) begin
        m_acc[b]   = ~m_acc[b];
        m_press[b] = m_acc[b];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process ----------------
  bit cmp_en   = 1'b0;
  int sr_run   = 0;
  int sr_last  = 0;
  int sr_rises = 0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_step_req",  step_req,  m_step);
      chk("cyc_clear_req", clear_req, m_clr);
      chk("cyc_running",   running,   m_run);
      chk("cyc_gen_count", gen_count, m_gen);
      chk("cyc_overrun",   overrun,   m_over);
    end
    if (step_req) sr_run++;
    else begin
      if (sr_run > 0) begin sr_last = sr_run; sr_rises++; end
      sr_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_run   = v;
      1: btn_step  = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int b, input int n);
    set_btn(b, 1'b1);
    cycles(n);
    set_btn(b, 1'b0);
    cycles(6);
  endtask

  task automatic wait_ticks(input int k, input string name);
    int t0;
    int lim;
    t0 = tick_cnt;
    lim = 0;
    while (tick_cnt < t0 + k && lim < 40 * k) begin cycles(1); lim++; end
    if (tick_cnt < t0 + k) chk(name, tick_cnt - t0, k);
  endtask

  task automatic wait_sig(input int which, input logic lvl, input int lim, input string name);
    int n;
    logic s;
    n = 0;
    s = (which == 0) ? step_req : clear_req;
    while (s !== lvl && n < lim) begin
      cycles(1); n++;
      s = (which == 0) ? step_req : clear_req;
    end
    chk(name, int'(s), int'(lvl));
  endtask

  int r0;

  // ---------------- main sequence ----------------
  initial begin
    cycles(3);
    cmp_en = 1'b1;
    chk("rst_step_req",  step_req,  0);
    chk("rst_clear_req", clear_req, 0);
    chk("rst_running",   running,   0);
    chk("rst_gen_count", gen_count, 0);
    chk("rst_overrun",   overrun,   0);
    rst = 1'b0;

    // 1: idle with ticks while paused
    cycles(100);
    chk("idle_no_step", sr_rises, 0);
    chk("idle_running", running, 0);
    chk("idle_gen", gen_count, 0);
    $display("phase 1 idle: gen=%0d running=%0d", gen_count, running);

    // 2: run mode, 5 ticks with a 3-cycle engine
    div_en = 1'b0;
    press(0, 6);
    chk("run_on", running, 1);
    div_en = 1'b1;
    wait_ticks(5, "run_ticks_timeout");
    cycles(6);
    chk("run_gen5", gen_count, 5);
    chk("run_no_overrun", overrun, 0);
    chk("run_req_width", sr_last, 3);
    $display("phase 2 run: gen=%0d req_width=%0d", gen_count, sr_last);

    // 3: slow engine causes overrun, dropped ticks do not queue
    eng_delay = 25;
    wait_ticks(3, "ovr_ticks_timeout");
    cycles(2);
    chk("ovr_flag", overrun, 1);
    chk("ovr_gen6", gen_count, 6);
    cycles(30);
    div_en = 1'b0;
    eng_delay = 3;
    press(0, 6);
    chk("ovr_gen7", gen_count, 7);
    chk("pause_running", running, 0);
    chk("ovr_sticky", overrun, 1);
    $display("phase 3 overrun: gen=%0d overrun=%0d", gen_count, overrun);

    // 4: step button glitch, real press, press while running
    r0 = sr_rises;
    btn_step = 1'b1; cycles(2); btn_step = 1'b0;
    cycles(10);
    chk("glitch_no_req", sr_rises - r0, 0);
    chk("glitch_gen", gen_count, 7);
    press(1, 6);
    cycles(10);
    chk("step_one_req", sr_rises - r0, 1);
    chk("step_gen8", gen_count, 8);
    press(0, 6);
    press(1, 6);
    cycles(5);
    chk("step_in_run_gen", gen_count, 8);
    chk("step_in_run_req", step_req, 0);
    $display("phase 4 step: gen=%0d running=%0d", gen_count, running);

    // 5: clear pressed while a step is busy
    eng_delay = 10;
    div_en = 1'b1;
    wait_sig(0, 1'b1, 60, "clr_wait_step");
    btn_clear = 1'b1; cycles(6); btn_clear = 1'b0;
    wait_sig(1, 1'b1, 40, "clr_wait_clear");
    chk("clr_step_done", gen_count, 9);
    wait_sig(1, 1'b0, 40, "clr_wait_done");
    cycles(2);
    chk("clr_gen0", gen_count, 0);
    chk("clr_overrun0", overrun, 0);
    chk("clr_running0", running, 0);
    eng_delay = 3;
    $display("phase 5 clear: gen=%0d running=%0d", gen_count, running);

    // 6: reset mid-handshake, clk_1s high across release, counter wrap
    press(0, 6);
    wait_sig(0, 1'b1, 60, "rst_wait_step");
    rst = 1'b1;
    cycles(1);
    chk("midrst_step_req", step_req, 0);
    chk("midrst_running", running, 0);
    div_en = 1'b0;
    clk_1s = 1'b1;
    div_cnt = 0;
    cycles(3);
    rst = 1'b0;
    cycles(5);
    chk("rel_no_req", step_req, 0);
    press(0, 6);
    chk("wrap_running", running, 1);
    div_en = 1'b1;
    wait_ticks(15, "wrap_ticks_timeout");
    cycles(6);
    chk("wrap_gen15", gen_count, 15);
    wait_ticks(1, "wrap_last_timeout");
    cycles(6);
    chk("wrap_gen0", gen_count, 0);
    chk("wrap_no_overrun", overrun, 0);
    $display("phase 6 wrap: gen=%0d", gen_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
